// File: rtl/mseq_pkg.sv
// Shared types and constants for micro_sequencer: micro-word layout, field
// offsets and the sequencer state encoding.
package mseq_pkg;

    localparam int MS_DEPTH = 16;
    localparam int MS_NREGS = 8;
    localparam int MS_SELW  = 4;
    localparam int MS_ALU_OPW = 1;
    localparam int MS_MUL_OPW = 1;
    localparam int MS_LOG_OPW = 2;

    // Bit offsets, LSB upward; each field starts where the previous one ends.
    localparam int MS_LAST_BIT      = 0;
    localparam int MS_RESULT_EN_BIT = MS_LAST_BIT + 1;
    localparam int MS_REG_EN_LSB    = MS_RESULT_EN_BIT + 1;
    localparam int MS_LOG_OP_LSB    = MS_REG_EN_LSB + MS_NREGS;
    localparam int MS_LOG_SEL2_LSB  = MS_LOG_OP_LSB + MS_LOG_OPW;
    localparam int MS_LOG_SEL1_LSB  = MS_LOG_SEL2_LSB + MS_SELW;
    localparam int MS_MUL_OP_LSB    = MS_LOG_SEL1_LSB + MS_SELW;
    localparam int MS_MUL_SEL2_LSB  = MS_MUL_OP_LSB + MS_MUL_OPW;
    localparam int MS_MUL_SEL1_LSB  = MS_MUL_SEL2_LSB + MS_SELW;
    localparam int MS_ALU_OP_LSB    = MS_MUL_SEL1_LSB + MS_SELW;
    localparam int MS_ALU_SEL2_LSB  = MS_ALU_OP_LSB + MS_ALU_OPW;
    localparam int MS_ALU_SEL1_LSB  = MS_ALU_SEL2_LSB + MS_SELW;
    localparam int MS_UW            = MS_ALU_SEL1_LSB + MS_SELW;

    typedef struct packed {
        logic [MS_SELW-1:0]    alu_sel1;
        logic [MS_SELW-1:0]    alu_sel2;
        logic [MS_ALU_OPW-1:0] alu_op;
        logic [MS_SELW-1:0]    mul_sel1;
        logic [MS_SELW-1:0]    mul_sel2;
        logic [MS_MUL_OPW-1:0] mul_op;
        logic [MS_SELW-1:0]    log_sel1;
        logic [MS_SELW-1:0]    log_sel2;
        logic [MS_LOG_OPW-1:0] log_op;
        logic [MS_NREGS-1:0]   reg_en;
        logic                  result_en;
        logic                  last;
    } uword_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mseq_cstore.sv
// Control store for micro_sequencer: DEPTH x UW words, synchronous write,
// asynchronous read. Contents are deliberately not reset.
module mseq_cstore #(
    parameter int DEPTH = 16,
    parameter int UW    = 38
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [UW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [UW-1:0]            rdata
);

    logic [UW-1:0] mem_r [DEPTH];

    // Word write on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Programmable micro-sequencer driving the ALU/MUL/LOG datapath selects and
// enables. Optional `hold` input when MICRO_SEQUENCER_HOLD_EN is defined.
module micro_sequencer
    import mseq_pkg::*;
#(
    parameter int DEPTH = MS_DEPTH,
    parameter int NREGS = MS_NREGS,
    parameter int SELW  = MS_SELW
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef MICRO_SEQUENCER_HOLD_EN
    input  logic                          hold,
`endif
    input  logic                          start,
    output logic                          op_ready,
    output logic                          done_next,
    output logic                          err,
    input  logic                          prog_we,
    input  logic [$clog2(DEPTH)-1:0]      prog_addr,
    input  logic [3*SELW*2+4+NREGS+1:0]   prog_data,
    output logic [SELW-1:0]               alu1_sel1,
    output logic [SELW-1:0]               alu1_sel2,
    output logic                          alu1_op,
    output logic [SELW-1:0]               mul1_sel1,
    output logic [SELW-1:0]               mul1_sel2,
    output logic                          mul1_op,
    output logic [SELW-1:0]               log1_sel1,
    output logic [SELW-1:0]               log1_sel2,
    output logic [1:0]                    log1_op,
    output logic [NREGS-1:0]              reg_en,
    output logic                          result_en
);

    localparam int AW = $clog2(DEPTH);
    localparam int UW = 3*SELW*2 + 4 + NREGS + 2;
    localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

    state_t        state_r, state_nx_s;
    logic [AW-1:0] pc_r, pc_nx_s;
    logic          err_r, err_nx_s;
    logic          hold_s;
    logic          cs_we_s;
    logic [UW-1:0] cs_rdata_s;
    uword_t        word_s;

`ifdef MICRO_SEQUENCER_HOLD_EN
    assign hold_s = hold;
`else
    assign hold_s = 1'b0;
`endif

    // Program writes only land while idle.
    assign cs_we_s = prog_we && (state_r == IDLE);
    assign word_s  = uword_t'(cs_rdata_s);

    mseq_cstore #(
        .DEPTH (DEPTH),
        .UW    (UW)
    ) u_cstore (
        .clk   (clk),
        .we    (cs_we_s),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_r),
        .rdata (cs_rdata_s)
    );

    // State, program counter and overflow flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pc_r    <= {AW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            err_r   <= err_nx_s;
        end
    end

    // Next-state logic; the last word never wraps, it ends the run with err.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        err_nx_s   = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                    pc_nx_s    = {AW{1'b0}};
                    err_nx_s   = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (hold_s) begin
                    state_nx_s = RUN;
                end else if (word_s.last) begin
                    state_nx_s = DONE;
                end else if (pc_r == PC_MAX) begin
                    state_nx_s = DONE;
                    err_nx_s   = 1'b1;
                end else begin
                    pc_nx_s = pc_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode: datapath controls only in RUN, enables masked by hold.
    always_comb begin
        op_ready  = 1'b0;
        done_next = 1'b0;
        err       = 1'b0;
        alu1_sel1 = {SELW{1'b0}};
        alu1_sel2 = {SELW{1'b0}};
        alu1_op   = 1'b0;
        mul1_sel1 = {SELW{1'b0}};
        mul1_sel2 = {SELW{1'b0}};
        mul1_op   = 1'b0;
        log1_sel1 = {SELW{1'b0}};
        log1_sel2 = {SELW{1'b0}};
        log1_op   = 2'b00;
        reg_en    = {NREGS{1'b0}};
        result_en = 1'b0;
        case (state_r)
            IDLE: op_ready = 1'b1;
            RUN: begin
                alu1_sel1 = word_s.alu_sel1;
                alu1_sel2 = word_s.alu_sel2;
                alu1_op   = word_s.alu_op;
                mul1_sel1 = word_s.mul_sel1;
                mul1_sel2 = word_s.mul_sel2;
                mul1_op   = word_s.mul_op;
                log1_sel1 = word_s.log_sel1;
                log1_sel2 = word_s.log_sel2;
                log1_op   = word_s.log_op;
                if (hold_s) begin
                    reg_en    = {NREGS{1'b0}};
                    result_en = 1'b0;
                end else begin
                    reg_en    = word_s.reg_en;
                    result_en = word_s.result_en;
                end
            end
            DONE: begin
                done_next = 1'b1;
                err       = err_r;
            end
            default: op_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer; define
// MICRO_SEQUENCER_HOLD_EN to also exercise the hold input.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        start;
    logic        op_ready, done_next, err;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [37:0] prog_data;
    logic [3:0]  alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2;
    logic        alu1_op, mul1_op, result_en;
    logic [1:0]  log1_op;
    logic [7:0]  reg_en;

    logic [37:0] exp_cs [16];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MICRO_SEQUENCER_HOLD_EN
        .hold      (hold),
`endif
        .start     (start),
        .op_ready  (op_ready),
        .done_next (done_next),
        .err       (err),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .alu1_sel1 (alu1_sel1),
        .alu1_sel2 (alu1_sel2),
        .alu1_op   (alu1_op),
        .mul1_sel1 (mul1_sel1),
        .mul1_sel2 (mul1_sel2),
        .mul1_op   (mul1_op),
        .log1_sel1 (log1_sel1),
        .log1_sel2 (log1_sel2),
        .log1_op   (log1_op),
        .reg_en    (reg_en),
        .result_en (result_en)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk(input logic [3:0] a1, input logic [3:0] a2, input logic ao,
                                       input logic [3:0] m1, input logic [3:0] m2, input logic mo,
                                       input logic [3:0] l1, input logic [3:0] l2, input logic [1:0] lo,
                                       input logic [7:0] re, input logic res, input logic last);
        return {a1, a2, ao, m1, m2, mo, l1, l2, lo, re, res, last};
    endfunction

    // Everything the DUT drives to the datapath, in micro-word order minus last.
    function automatic logic [36:0] obs_word();
        return {alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
                log1_sel1, log1_sel2, log1_op, reg_en, result_en};
    endfunction

    task automatic prog(input logic [3:0] addr, input logic [37:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        exp_cs[addr] = data;
        step();
        prog_we = 1'b0;
    endtask

    // mode 0: plain run; 1: write word 0 together with start; 2: write word 0 during RUN (ignored)
    task automatic run_check(input int n, input logic exp_err, input int mode, input logic [37:0] wdata);
        check("idle_ready", op_ready, 64'd1);
        start = 1'b1;
        if (mode == 1) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = wdata;
            exp_cs[0] = wdata;
        end
        step();
        start   = 1'b0;
        prog_we = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mode == 2 && i == 0) begin
                prog_we   = 1'b1;
                prog_addr = 4'd0;
                prog_data = wdata;
            end
            check("run_word", obs_word(), exp_cs[i][37:1]);
            check("run_flags", {done_next, op_ready, err}, 64'd0);
            step();
            prog_we = 1'b0;
        end
        check("done_pulse", done_next, 64'd1);
        check("done_err", err, exp_err);
        check("done_outs", obs_word(), 64'd0);
        step();
        check("post_ready", {op_ready, done_next, err}, 64'h4);
    endtask

    initial begin
        logic [36:0] en_mask;
        en_mask   = ~37'h1FF;
        rst       = 1'b1;
        hold      = 1'b0;
        start     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 38'd0;
        step();
        step();
        rst = 1'b0;
        check("reset_ready", {op_ready, done_next, err}, 64'h4);
        check("reset_outs", obs_word(), 64'd0);

        // 4-word schedule, last on word 3
        prog(4'd0, mk(4'd1, 4'd2, 1'b1, 4'd3, 4'd4, 1'b0, 4'd5, 4'd6, 2'd1, 8'h01, 1'b0, 1'b0));
        prog(4'd1, mk(4'd7, 4'd8, 1'b0, 4'd9, 4'd10, 1'b1, 4'd11, 4'd12, 2'd2, 8'h12, 1'b0, 1'b0));
        prog(4'd2, mk(4'd13, 4'd14, 1'b1, 4'd15, 4'd0, 1'b1, 4'd1, 4'd3, 2'd3, 8'hA4, 1'b1, 1'b0));
        prog(4'd3, mk(4'd15, 4'd15, 1'b1, 4'd15, 4'd15, 1'b1, 4'd15, 4'd15, 2'd3, 8'hFF, 1'b1, 1'b1));
        run_check(4, 1'b0, 0, 38'd0);

        // single word: alu 2/3, op 0, reg_en 8'h08, result_en, last
        prog(4'd0, mk(4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'd0, 8'h08, 1'b1, 1'b1));
        run_check(1, 1'b0, 0, 38'd0);

        // all 16 words without last: overflow ends the run with err
        for (int i = 0; i < 16; i++) begin
            prog(4'(i), mk(4'(i), 4'(15 - i), i[0], 4'(i + 1), 4'(i + 2), i[1],
                           4'(i + 3), 4'(i + 5), 2'(i), 8'(1 << (i % 8)), i[2], 1'b0));
        end
        run_check(16, 1'b1, 0, 38'd0);
        prog(4'd5, mk(4'd5, 4'd5, 1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 4'd5, 2'd1, 8'h55, 1'b1, 1'b1));
        run_check(6, 1'b0, 0, 38'd0);

        // write during RUN is dropped; write with start lands before the first RUN cycle
        prog(4'd1, mk(4'd6, 4'd1, 1'b1, 4'd2, 4'd8, 1'b0, 4'd4, 4'd9, 2'd2, 8'h80, 1'b1, 1'b1));
        run_check(2, 1'b0, 2, mk(4'd9, 4'd9, 1'b0, 4'd9, 4'd9, 1'b0, 4'd9, 4'd9, 2'd0, 8'h99, 1'b0, 1'b0));
        run_check(2, 1'b0, 0, 38'd0);
        run_check(2, 1'b0, 1, mk(4'd12, 4'd11, 1'b1, 4'd10, 4'd9, 1'b1, 4'd8, 4'd7, 2'd3, 8'h3C, 1'b0, 1'b0));

        // 3-word schedule, reset in its 2nd RUN cycle
        prog(4'd0, mk(4'd1, 4'd1, 1'b0, 4'd2, 4'd2, 1'b1, 4'd3, 4'd3, 2'd1, 8'h11, 1'b1, 1'b0));
        prog(4'd1, mk(4'd4, 4'd4, 1'b1, 4'd5, 4'd5, 1'b0, 4'd6, 4'd6, 2'd2, 8'h22, 1'b1, 1'b0));
        prog(4'd2, mk(4'd7, 4'd7, 1'b0, 4'd8, 4'd8, 1'b1, 4'd9, 4'd9, 2'd3, 8'h44, 1'b0, 1'b1));
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_run0", obs_word(), exp_cs[0][37:1]);
        step();
        check("rst_run1", obs_word(), exp_cs[1][37:1]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ready", {op_ready, done_next, err}, 64'h4);
        check("rst_outs", obs_word(), 64'd0);
        step();
        check("rst_no_done", {op_ready, done_next}, 64'h2);
        run_check(3, 1'b0, 0, 38'd0);

`ifdef MICRO_SEQUENCER_HOLD_EN
        // hold for two cycles at pc=1 delays done_next by two cycles
        start = 1'b1;
        step();
        start = 1'b0;
        check("hold_w0", obs_word(), exp_cs[0][37:1]);
        step();
        hold = 1'b1;
        check("hold_a", obs_word(), exp_cs[1][37:1] & en_mask);
        step();
        check("hold_b", obs_word(), exp_cs[1][37:1] & en_mask);
        check("hold_nodone", {done_next, op_ready}, 64'd0);
        step();
        hold = 1'b0;
        check("hold_w1", obs_word(), exp_cs[1][37:1]);
        step();
        check("hold_w2", obs_word(), exp_cs[2][37:1]);
        step();
        check("hold_done", {done_next, err}, 64'h2);
        step();
        check("hold_ready", op_ready, 64'd1);
`else
        check("mask_const", {27'd0, en_mask[8:0]}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
